xbus_bsmem_slave: RTL and testbench
===================================

XBUS_BSMEM_SLAVE -- requirements
Module: xbus_bsmem_slave

Interface
REQ-001 SHALL have parameter AW, default 10, meaning log2 of memory depth in 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'h0, meaning the first word address decoded by this slave.
REQ-003 SHALL have parameter LATENCY, default 2, meaning edges from accept to sl_ack, legal range 1..15.
REQ-004 SHALL have port clk  in  1  clock, all logic rising-edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port xbs_select  in  1  xbus transfer strobe from the granted master.
REQ-007 SHALL have port xbs_addr  in  32  word address, incrementing by 1 per word.
REQ-008 SHALL have port xbs_data  in  32  write data from the master.
REQ-009 SHALL have port xbs_rnw  in  1  1 = read, 0 = write.
REQ-010 SHALL have port xbs_be  in  4  byte enables, bit i covers data[8i+7:8i].
REQ-011 SHALL have port sl_ack  out  1  one-cycle transfer-complete pulse.
REQ-012 SHALL have port sl_data  out  32  read data, valid only while sl_ack=1.
REQ-013 SHALL have port sl_err  out  1  out-of-range flag, coincident with sl_ack.
REQ-014 SHALL have port rd_cnt  out  16  saturating count of completed in-range reads.
REQ-015 SHALL have port wr_cnt  out  16  saturating count of completed in-range writes.

Function
REQ-016 SHALL store 2^AW x 32-bit words; an access is in range iff BASE <= addr < BASE+2^AW, and the index is addr-BASE truncated to AW bits.
REQ-017 SHALL implement the FSM states IDLE, WAIT, ACK and RECOV, with all outputs registered.
REQ-018 SHALL, in IDLE with xbs_select=1, accept the transfer: latch addr, data, rnw and be, and load the latency counter.
REQ-019 SHALL go from IDLE to ACK when LATENCY=1, and to WAIT otherwise.
REQ-020 SHALL place sl_ack high in the cycle after the LATENCY-th edge counted from the accept edge; with LATENCY=2, ack is high 2 cycles after the accept cycle.
REQ-021 SHALL, in WAIT, count down and enter ACK when the count expires while xbs_select is still high.
REQ-022 SHALL treat xbs_select low in WAIT as an abort: go to IDLE with no write, no ack and no counter change.
REQ-023 SHALL drive sl_ack=1 for exactly one cycle in ACK, then go to RECOV unconditionally.
REQ-024 SHALL stay in RECOV until xbs_select=0, then go to IDLE, so a held select never produces a second ack.
REQ-025 SHALL commit an in-range write on the edge entering ACK, updating only the enabled bytes; be=4'h0 completes with ack but changes nothing.
REQ-026 SHALL register an in-range read word into sl_data on the edge entering ACK.
REQ-027 SHALL hold sl_data at 32'h0 in all states other than ACK.
REQ-028 SHALL, for an out-of-range access, still ack with normal timing, assert sl_err with sl_ack, return sl_data=32'hDEAD_BEEF for reads, and drop writes.
REQ-029 SHALL increment rd_cnt or wr_cnt by 1 on each in-range ack and saturate at 16'hFFFF; out-of-range acks increment neither.
REQ-030 SHALL, for a read and a write to the same word in consecutive transfers, return the newly written value to the read.
REQ-031 SHALL keep memory contents uninitialised; only control and output registers are reset.

Reset
REQ-032 SHALL, when rstn=0 at any time, immediately force state IDLE, sl_ack=0, sl_err=0, sl_data=0, rd_cnt=0, wr_cnt=0 and counter=0.
REQ-033 SHALL drop a write whose ACK edge has not yet occurred when reset asserts mid-transfer.
REQ-034 SHALL accept the first transfer no earlier than the first rising edge after rstn deasserts.

Verification
REQ-035 SHALL cover: write addr BASE+5, data 32'hA5A5_1234, be=4'hF, LATENCY=2 -> ack 2 cycles after accept; a read of BASE+5 then returns 32'hA5A5_1234 with sl_err=0 and wr_cnt=1, rd_cnt=1.
REQ-036 SHALL cover: preload 32'h1122_3344, write 32'hAABB_CCDD with be=4'b0101 -> a read returns 32'h11BB_33DD.
REQ-037 SHALL cover: read of addr BASE+2^AW -> one ack with sl_err=1 and sl_data=32'hDEAD_BEEF; counters unchanged.
REQ-038 SHALL cover: select dropped in WAIT -> no ack; a following read of the same word shows old data; select held high 5 cycles after ack -> exactly one ack.
REQ-039 SHALL cover: a 16-word burst at BASE with select dropped for 1 cycle after each ack, LATENCY=1 and LATENCY=15 -> 16 acks, correct data, and ack spacing of LATENCY+2 cycles.
REQ-040 SHALL cover: rstn pulsed low while in WAIT of a write -> all outputs 0 immediately, and the target word is not modified.

Source files
------------

// File: rtl/xbus_bsmem_slave.sv
// Byte-strobed single-port memory slave on the xbus.
// Fixed-latency ack, out-of-range error response, saturating access counters.
module xbus_bsmem_slave #(
    parameter int          AW      = 10,
    parameter logic [31:0] BASE    = 32'h0,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        xbs_select,
    input  logic [31:0] xbs_addr,
    input  logic [31:0] xbs_data,
    input  logic        xbs_rnw,
    input  logic [3:0]  xbs_be,
    output logic        sl_ack,
    output logic [31:0] sl_data,
    output logic        sl_err,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, RECOV} state_t;

    // The accept edge already counts as the first edge of the latency.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        rnw_q;
    logic [3:0]  be_q;
    logic        ack_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [15:0] rdCnt_q;
    logic [15:0] wrCnt_q;

    logic [31:0] mem [2**AW];

    logic        fire_d;
    logic [31:0] opAddr_d;
    logic [31:0] opData_d;
    logic        opRnw_d;
    logic [3:0]  opBe_d;
    logic [32:0] off_d;
    logic        inRange_d;
    logic [AW-1:0] idx_d;

    // With LATENCY=1 the transfer completes on its accept edge, so it must use the live bus.
    always_comb begin
        if (state_q == IDLE) begin
            opAddr_d = xbs_addr;
            opData_d = xbs_data;
            opRnw_d  = xbs_rnw;
            opBe_d   = xbs_be;
        end else begin
            opAddr_d = addr_q;
            opData_d = data_q;
            opRnw_d  = rnw_q;
            opBe_d   = be_q;
        end
        fire_d    = xbs_select && (((state_q == IDLE) && (LATENCY == 1)) ||
                                   ((state_q == WAIT) && (cnt_q == 4'd0)));
        off_d     = {1'b0, opAddr_d} - {1'b0, BASE};
        inRange_d = (off_d[32:AW] == '0);
        idx_d     = off_d[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rstn && fire_d && inRange_d && !opRnw_d) begin
            for (int b = 0; b < 4; b++) begin
                if (opBe_d[b]) mem[idx_d][8*b +: 8] <= opData_d[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            rnw_q   <= 1'b0;
            be_q    <= 4'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            rdCnt_q <= 16'h0;
            wrCnt_q <= 16'h0;
        end else begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            if (fire_d) begin
                state_q <= ACK;
                ack_q   <= 1'b1;
                err_q   <= !inRange_d;
                if (opRnw_d) rdata_q <= inRange_d ? mem[idx_d] : 32'hDEAD_BEEF;
                if (inRange_d) begin
                    if (opRnw_d) begin
                        if (rdCnt_q != 16'hFFFF) rdCnt_q <= rdCnt_q + 16'd1;
                    end else begin
                        if (wrCnt_q != 16'hFFFF) wrCnt_q <= wrCnt_q + 16'd1;
                    end
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (xbs_select) begin
                            addr_q  <= xbs_addr;
                            data_q  <= xbs_data;
                            rnw_q   <= xbs_rnw;
                            be_q    <= xbs_be;
                            cnt_q   <= CNT_LOAD;
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (!xbs_select) state_q <= IDLE;
                        else             cnt_q   <= cnt_q - 4'd1;
                    end
                    ACK:     state_q <= RECOV;
                    RECOV: begin
                        if (!xbs_select) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sl_ack  = ack_q;
    assign sl_err  = err_q;
    assign sl_data = rdata_q;
    assign rd_cnt  = rdCnt_q;
    assign wr_cnt  = wrCnt_q;

endmodule

// File: tb/tb_xbus_bsmem_slave.sv
// Bench for xbus_bsmem_slave: three instances (LATENCY 2, 1, 15) checked against
// a word-array model with per-byte known flags and plain access counters.
module tb_xbus_bsmem_slave;

    localparam int          AW    = 6;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0040;
    localparam int          LAT0  = 2;
    localparam int          LAT1  = 1;
    localparam int          LAT2  = 15;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic [2:0]  selv  = 3'b000;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        rnw   = 1'b0;
    logic [3:0]  be    = 4'h0;
    logic        ackv  [3];
    logic        errv  [3];
    logic [31:0] datav [3];
    logic [15:0] rdv   [3];
    logic [15:0] wrv   [3];

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    logic [31:0] mdl [3][DEPTH];
    bit   [3:0]  kn  [3][DEPTH];
    int          mRd [3];
    int          mWr [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    xbus_bsmem_slave #(.AW(AW), .BASE(BASE), .LATENCY(LAT0)) dut0 (
        .clk(clk), .rstn(rstn), .xbs_select(selv[0]), .xbs_addr(addr), .xbs_data(wdata),
        .xbs_rnw(rnw), .xbs_be(be), .sl_ack(ackv[0]), .sl_data(datav[0]), .sl_err(errv[0]),
        .rd_cnt(rdv[0]), .wr_cnt(wrv[0]));
    xbus_bsmem_slave #(.AW(AW), .BASE(BASE), .LATENCY(LAT1)) dut1 (
        .clk(clk), .rstn(rstn), .xbs_select(selv[1]), .xbs_addr(addr), .xbs_data(wdata),
        .xbs_rnw(rnw), .xbs_be(be), .sl_ack(ackv[1]), .sl_data(datav[1]), .sl_err(errv[1]),
        .rd_cnt(rdv[1]), .wr_cnt(wrv[1]));
    xbus_bsmem_slave #(.AW(AW), .BASE(BASE), .LATENCY(LAT2)) dut2 (
        .clk(clk), .rstn(rstn), .xbs_select(selv[2]), .xbs_addr(addr), .xbs_data(wdata),
        .xbs_rnw(rnw), .xbs_be(be), .sl_ack(ackv[2]), .sl_data(datav[2]), .sl_err(errv[2]),
        .rd_cnt(rdv[2]), .wr_cnt(wrv[2]));

    function automatic int latOf(input int k);
        case (k)
            0:       return LAT0;
            1:       return LAT1;
            default: return LAT2;
        endcase
    endfunction

    // Reference model of one completed access: returns expected read data, mask of known bytes and error flag.
    function automatic void mdlAccess(input int k, input logic r, input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] b, output logic [31:0] expD,
                                      output logic [31:0] mask, output logic expE);
        longint off = longint'({32'h0, a}) - longint'({32'h0, BASE});
        expD = 32'h0;
        mask = 32'h0;
        if (off >= 0 && off < DEPTH) begin
            int idx = int'(off);
            expE = 1'b0;
            if (r) begin
                expD = mdl[k][idx];
                for (int i = 0; i < 4; i++) if (kn[k][idx][i]) mask[8*i +: 8] = 8'hFF;
                if (mRd[k] < 65535) mRd[k]++;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) begin
                        mdl[k][idx][8*i +: 8] = d[8*i +: 8];
                        kn[k][idx][i] = 1'b1;
                    end
                end
                if (mWr[k] < 65535) mWr[k]++;
            end
        end else begin
            expE = 1'b1;
            if (r) begin
                expD = 32'hDEAD_BEEF;
                mask = 32'hFFFF_FFFF;
            end
        end
    endfunction

    // One bus transfer; select is held for 'hold' cycles after the ack, then dropped for one cycle.
    task automatic applyStimulus(input int k, input logic r, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] b, input int hold, output int lat, output int ackCyc,
                                 output logic [31:0] got, output logic gotE, output int extra,
                                 output logic [31:0] expD, output logic [31:0] mask, output logic expE);
        @(posedge clk); #1;
        selv[k] = 1'b1; addr = a; wdata = d; rnw = r; be = b;
        lat = -1; ackCyc = 0; got = 32'h0; gotE = 1'b0; extra = 0;
        expD = 32'h0; mask = 32'h0; expE = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ackv[k] === 1'b1) begin
                lat = n; ackCyc = cyc; got = datav[k]; gotE = errv[k];
                break;
            end
        end
        if (lat < 0) begin
            tests++; failed++;
            $display("[TB] FAIL ack_timeout dut%0d addr %h: no ack within 40 cycles", k, a);
        end else begin
            mdlAccess(k, r, a, d, b, expD, mask, expE);
        end
        for (int n = 0; n < hold; n++) begin
            @(posedge clk); #1;
            if (ackv[k] === 1'b1) extra++;
        end
        @(posedge clk); #1;
        selv[k] = 1'b0;
    endtask

    task automatic test_reset();
        selv = 3'b000;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            mRd[k] = 0; mWr[k] = 0;
            tests++;
            if (ackv[k] !== 1'b0 || errv[k] !== 1'b0 || datav[k] !== 32'h0 || rdv[k] !== 16'h0 || wrv[k] !== 16'h0) begin
                failed++;
                $display("[TB] FAIL reset_outputs dut%0d: ack=%b err=%b data=%h rd=%h wr=%h, required all zero",
                         k, ackv[k], errv[k], datav[k], rdv[k], wrv[k]);
            end
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (ackv[0] !== 1'b0) begin
            failed++;
            $display("[TB] FAIL idle_ack: ack=%b required 0", ackv[0]);
        end
    endtask

    task automatic test_basic();
        int lat, ac, ex; logic [31:0] got, expD, mask; logic ge, expE;
        applyStimulus(0, 1'b0, BASE + 5, 32'hA5A5_1234, 4'hF, 0, lat, ac, got, ge, ex, expD, mask, expE);
        tests++;
        if (lat !== LAT0 || ge !== 1'b0) begin
            failed++;
            $display("[TB] FAIL basic_write: latency %0d err %b, required %0d err 0", lat, ge, LAT0);
        end
        applyStimulus(0, 1'b1, BASE + 5, 32'h0, 4'hF, 0, lat, ac, got, ge, ex, expD, mask, expE);
        tests++;
        if (got !== 32'hA5A5_1234 || ge !== 1'b0 || lat !== LAT0) begin
            failed++;
            $display("[TB] FAIL basic_read: data %h err %b lat %0d, required A5A51234 err 0 lat %0d", got, ge, lat, LAT0);
        end
        tests++;
        if (wrv[0] !== 16'd1 || rdv[0] !== 16'd1) begin
            failed++;
            $display("[TB] FAIL basic_counters: wr %0d rd %0d, required 1 and 1", wrv[0], rdv[0]);
        end
    endtask

    task automatic test_byte_enable();
        int lat, ac, ex; logic [31:0] got, expD, mask; logic ge, expE;
        applyStimulus(0, 1'b0, BASE + 7, 32'h1122_3344, 4'hF, 0, lat, ac, got, ge, ex, expD, mask, expE);
        applyStimulus(0, 1'b0, BASE + 7, 32'hAABB_CCDD, 4'b0101, 0, lat, ac, got, ge, ex, expD, mask, expE);
        applyStimulus(0, 1'b1, BASE + 7, 32'h0, 4'hF, 0, lat, ac, got, ge, ex, expD, mask, expE);
        tests++;
        if (got !== 32'h11BB_33DD || got !== expD) begin
            failed++;
            $display("[TB] FAIL byte_enable: data %h, required 11BB33DD", got);
        end
        applyStimulus(0, 1'b0, BASE + 7, 32'hFFFF_FFFF, 4'h0, 0, lat, ac, got, ge, ex, expD, mask, expE);
        tests++;
        if (lat !== LAT0) begin
            failed++;
            $display("[TB] FAIL be_zero_ack: latency %0d, required %0d", lat, LAT0);
        end
        applyStimulus(0, 1'b1, BASE + 7, 32'h0, 4'hF, 0, lat, ac, got, ge, ex, expD, mask, expE);
        tests++;
        if (got !== 32'h11BB_33DD) begin
            failed++;
            $display("[TB] FAIL be_zero_data: data %h, required 11BB33DD", got);
        end
        tests++;
        if (wrv[0] !== 16'(mWr[0]) || rdv[0] !== 16'(mRd[0])) begin
            failed++;
            $display("[TB] FAIL be_counters: wr %0d rd %0d, required %0d %0d", wrv[0], rdv[0], mWr[0], mRd[0]);
        end
    endtask

    task automatic test_out_of_range();
        int lat, ac, ex; logic [31:0] got, expD, mask; logic ge, expE;
        logic [15:0] r0, w0;
        r0 = rdv[0]; w0 = wrv[0];
        applyStimulus(0, 1'b1, BASE + DEPTH, 32'h0, 4'hF, 0, lat, ac, got, ge, ex, expD, mask, expE);
        tests++;
        if (ge !== 1'b1 || got !== 32'hDEAD_BEEF || lat !== LAT0) begin
            failed++;
            $display("[TB] FAIL oor_read_high: err %b data %h lat %0d, required 1 DEADBEEF %0d", ge, got, lat, LAT0);
        end
        applyStimulus(0, 1'b0, BASE - 1, 32'h5555_5555, 4'hF, 0, lat, ac, got, ge, ex, expD, mask, expE);
        tests++;
        if (ge !== 1'b1) begin
            failed++;
            $display("[TB] FAIL oor_write_low: err %b, required 1", ge);
        end
        applyStimulus(0, 1'b1, BASE - 1, 32'h0, 4'hF, 0, lat, ac, got, ge, ex, expD, mask, expE);
        tests++;
        if (ge !== 1'b1 || got !== 32'hDEAD_BEEF) begin
            failed++;
            $display("[TB] FAIL oor_read_low: err %b data %h, required 1 DEADBEEF", ge, got);
        end
        tests++;
        if (rdv[0] !== r0 || wrv[0] !== w0) begin
            failed++;
            $display("[TB] FAIL oor_counters: rd %0d wr %0d, required %0d %0d", rdv[0], wrv[0], r0, w0);
        end
    endtask

    task automatic test_abort();
        int lat, ac, ex, acks; logic [31:0] got, expD, mask; logic ge, expE;
        logic [15:0] w0;
        applyStimulus(0, 1'b0, BASE + 9, 32'h1234_5678, 4'hF, 0, lat, ac, got, ge, ex, expD, mask, expE);
        w0 = wrv[0];
        @(posedge clk); #1;
        selv[0] = 1'b1; addr = BASE + 9; wdata = 32'h9999_0000; rnw = 1'b0; be = 4'hF;
        @(posedge clk); #1;
        selv[0] = 1'b0;
        acks = 0;
        for (int n = 0; n < 6; n++) begin
            if (ackv[0] === 1'b1) acks++;
            @(posedge clk); #1;
        end
        tests++;
        if (acks != 0 || wrv[0] !== w0) begin
            failed++;
            $display("[TB] FAIL abort_no_ack: acks %0d wr %0d, required 0 acks wr %0d", acks, wrv[0], w0);
        end
        applyStimulus(0, 1'b1, BASE + 9, 32'h0, 4'hF, 0, lat, ac, got, ge, ex, expD, mask, expE);
        tests++;
        if (got !== 32'h1234_5678) begin
            failed++;
            $display("[TB] FAIL abort_old_data: data %h, required 12345678", got);
        end
        applyStimulus(0, 1'b1, BASE + 9, 32'h0, 4'hF, 5, lat, ac, got, ge, ex, expD, mask, expE);
        tests++;
        if (ex != 0 || lat !== LAT0 || got !== 32'h1234_5678) begin
            failed++;
            $display("[TB] FAIL held_select: extra acks %0d lat %0d data %h, required 0 %0d 12345678", ex, lat, LAT0, got);
        end
    endtask

    task automatic test_random();
        int lat, ac, ex; logic [31:0] got, expD, mask, a, d; logic ge, expE, r;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 1'b0, BASE + i, $urandom, 4'hF, 0, lat, ac, got, ge, ex, expD, mask, expE);
        end
        for (int i = 0; i < 60; i++) begin
            a = BASE - 4 + $urandom_range(0, DEPTH + 7);
            d = $urandom;
            r = 1'($urandom_range(0, 1));
            applyStimulus(0, r, a, d, 4'($urandom_range(0, 15)), 0, lat, ac, got, ge, ex, expD, mask, expE);
            tests++;
            if (lat !== LAT0 || ge !== expE || (got & mask) !== (expD & mask)) begin
                failed++;
                $display("[TB] FAIL random_access %0d addr %h rnw %b: lat %0d err %b data %h, required lat %0d err %b data %h mask %h",
                         i, a, r, lat, ge, got, LAT0, expE, expD, mask);
            end
        end
        tests++;
        if (wrv[0] !== 16'(mWr[0]) || rdv[0] !== 16'(mRd[0])) begin
            failed++;
            $display("[TB] FAIL random_counters: wr %0d rd %0d, required %0d %0d", wrv[0], rdv[0], mWr[0], mRd[0]);
        end
    endtask

    task automatic test_burst(input int k);
        int lat, ac, ex, prev; logic [31:0] got, expD, mask; logic ge, expE;
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(k, 1'b0, BASE + i, $urandom, 4'hF, 0, lat, ac, got, ge, ex, expD, mask, expE);
            tests++;
            if (lat !== latOf(k) || (i > 0 && ac - prev != latOf(k) + 2)) begin
                failed++;
                $display("[TB] FAIL burst_write dut%0d word %0d: lat %0d spacing %0d, required %0d and %0d",
                         k, i, lat, ac - prev, latOf(k), latOf(k) + 2);
            end
            prev = ac;
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(k, 1'b1, BASE + i, 32'h0, 4'hF, 0, lat, ac, got, ge, ex, expD, mask, expE);
            tests++;
            if (lat !== latOf(k) || ac - prev != latOf(k) + 2 || got !== expD || ge !== 1'b0) begin
                failed++;
                $display("[TB] FAIL burst_read dut%0d word %0d: lat %0d spacing %0d data %h err %b, required %0d %0d %h 0",
                         k, i, lat, ac - prev, got, ge, latOf(k), latOf(k) + 2, expD);
            end
            prev = ac;
        end
        tests++;
        if (wrv[k] !== 16'd16 || rdv[k] !== 16'd16) begin
            failed++;
            $display("[TB] FAIL burst_counters dut%0d: wr %0d rd %0d, required 16 16", k, wrv[k], rdv[k]);
        end
    endtask

    task automatic test_reset_mid();
        int lat, ac, ex; logic [31:0] got, expD, mask; logic ge, expE;
        applyStimulus(0, 1'b0, BASE + 11, 32'hC0FF_EE01, 4'hF, 0, lat, ac, got, ge, ex, expD, mask, expE);
        @(posedge clk); #1;
        selv[0] = 1'b1; addr = BASE + 11; wdata = 32'h0BAD_F00D; rnw = 1'b0; be = 4'hF;
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            mRd[k] = 0; mWr[k] = 0;
            tests++;
            if (ackv[k] !== 1'b0 || errv[k] !== 1'b0 || datav[k] !== 32'h0 || rdv[k] !== 16'h0 || wrv[k] !== 16'h0) begin
                failed++;
                $display("[TB] FAIL midreset_outputs dut%0d: ack=%b err=%b data=%h rd=%h wr=%h, required all zero",
                         k, ackv[k], errv[k], datav[k], rdv[k], wrv[k]);
            end
        end
        selv[0] = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        applyStimulus(0, 1'b1, BASE + 11, 32'h0, 4'hF, 0, lat, ac, got, ge, ex, expD, mask, expE);
        tests++;
        if (got !== 32'hC0FF_EE01 || rdv[0] !== 16'd1) begin
            failed++;
            $display("[TB] FAIL midreset_word: data %h rd %0d, required C0FFEE01 and 1", got, rdv[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_enable();
        test_out_of_range();
        test_abort();
        test_random();
        test_burst(1);
        test_burst(2);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
